// File: rtl/div_share_arbiter_pkg.sv
// div_pkg: FSM state encoding, default widths and the round-robin grant helper
// shared by the divider arbiter top, its arbiter sub-module and its interface.
package div_pkg;

    localparam int N_DEF     = 4;
    localparam int NREQ_DEF  = 2;
    localparam int IDW_DEF   = 1;

    // Upper bound on requesters the grant search can handle.
    localparam int RR_IDXW   = 5;
    localparam int RR_MAXREQ = 1 << RR_IDXW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index of the first set bit of valid at or above ptr, wrapping within
    // nreq. Returns nreq when no bit is set. Scanning from the far end lets
    // the lowest rotated position overwrite the result last.
    function automatic int unsigned rr_next_grant(
        input logic [RR_MAXREQ-1:0] valid,
        input int unsigned          ptr,
        input int unsigned          nreq
    );
        int unsigned idx;
        rr_next_grant = nreq;
        for (int k = RR_MAXREQ - 1; k >= 0; k--) begin
            if (unsigned'(k) < nreq) begin
                idx = ptr + unsigned'(k);
                if (idx >= nreq) idx = idx - nreq;
                if (valid[idx[RR_IDXW-1:0]]) rr_next_grant = idx;
            end
        end
    endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the requesters (master) and the shared
// divider arbiter (slave). Request operands are packed per requester.
interface div_share_arbiter_if
    import div_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_q;
    logic [N-1:0]      rsp_r;
    logic              rsp_error;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_error
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_error
    );
endinterface

// File: rtl/div_share_arbiter_rr_arbiter.sv
// div_rr_arbiter: purely combinational round-robin picker. Produces a one-hot
// grant (or all zero) for the first valid requester at or above ptr.
module div_rr_arbiter
    import div_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic [RR_MAXREQ-1:0] valid_ext;
    int unsigned          pick;

    // Rotating-priority search, then expand the winning index to one-hot.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = req_valid;
        pick                  = rr_next_grant(valid_ext, 32'(ptr), NREQ);
        grant                 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == unsigned'(i)) grant[i] = 1'b1;
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one restoring shift-subtract unsigned divider
// between NREQ requesters with round-robin arbitration and a single tagged
// response channel. Divide-by-zero skips the shift phase and flags an error.
// Optional build macro DIV_ARB_STATS_EN adds 16-bit response/div0 counters.
module div_share_arbiter
    import div_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    div_share_arbiter_if.slave bus,
    output logic               busy
`ifdef DIV_ARB_STATS_EN
    ,
    output logic [15:0]        stat_ops,
    output logic [15:0]        stat_div0
`endif
);

    localparam int CW = $clog2(N + 1);

    state_t          state, state_n;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [2*N-1:0]  data;
    logic [N-1:0]    divisor;
    logic [CW-1:0]   count;
    logic            err;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic [N-1:0]    sel_x;
    logic [N-1:0]    sel_y;
    logic            accept;
    logic            rsp_fire;
    logic [N:0]      partial;
    logic [N-1:0]    diff;
    logic [2*N-1:0]  data_step;

    div_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant)
    );

    // Encode the granted index and mux out its operands.
    always_comb begin
        gid   = '0;
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gid   = IDW'(i);
                sel_x = bus.req_x[i*N +: N];
                sel_y = bus.req_y[i*N +: N];
            end
        end
    end

    assign accept   = (state == IDLE) && |(bus.req_valid & grant);
    assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

    // One restoring division step; when the trial subtraction fits, the
    // difference is below the divisor, so its low N bits are exact.
    always_comb begin
        partial = data[2*N-1:N-1];
        diff    = partial[N-1:0] - divisor;
        if (partial >= {1'b0, divisor}) data_step = {diff, data[N-2:0], 1'b1};
        else                            data_step = {data[2*N-2:0], 1'b0};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_n       = state;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                bus.req_ready = grant;
                if (accept) state_n = (sel_y == '0) ? RESP : SHIFT;
            end
            SHIFT: begin
                if (count == CW'(1)) state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (rsp_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, pointer advance and the shift-subtract datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr     <= '0;
            id      <= '0;
            data    <= '0;
            divisor <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id      <= gid;
                        ptr     <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
                        divisor <= sel_y;
                        if (sel_y == '0) begin
                            data  <= '0;
                            count <= '0;
                            err   <= 1'b1;
                        end else begin
                            data  <= {{N{1'b0}}, sel_x};
                            count <= CW'(N);
                            err   <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    data  <= data_step;
                    count <= count - 1'b1;
                end
                RESP: begin
                    if (rsp_fire) err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_q     = data[N-1:0];
    assign bus.rsp_r     = data[2*N-1:N];
    assign bus.rsp_id    = id;
    assign bus.rsp_error = err;

`ifdef DIV_ARB_STATS_EN
    // Count completed responses and those that carried divide-by-zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ops  <= '0;
            stat_div0 <= '0;
        end else if (rsp_fire) begin
            stat_ops <= stat_ops + 16'd1;
            if (err) stat_div0 <= stat_div0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed scenarios followed by random traffic,
// checked by a cycle-level reference model and a response scoreboard.
module tb_div_share_arbiter;
    import div_pkg::*;

    localparam int N    = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic [NREQ-1:0] drv_valid;
    logic [N-1:0]    drv_x [NREQ];
    logic [N-1:0]    drv_y [NREQ];
    logic            drv_rsp_ready;
`ifdef DIV_ARB_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_div0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    exp_t sb[$];
    bit   m_on   = 1'b0;
    bit   m_busy = 1'b0;
    bit   m_err  = 1'b0;
    int   m_rem  = 0;
    int   m_ptr  = 0;
    int   m_ops  = 0;
    int   m_div0 = 0;

    div_share_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    div_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef DIV_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_div0 (stat_div0)
`endif
    );

    always #5 clock = ~clock;

    assign bus.req_valid = drv_valid;
    assign bus.rsp_ready = drv_rsp_ready;

    always_comb begin
        bus.req_x = '0;
        bus.req_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*N +: N] = drv_x[i];
            bus.req_y[i*N +: N] = drv_y[i];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First valid requester starting at p, wrapping; -1 when none.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Cycle model: checks handshake outputs, then advances to the next edge.
    always @(negedge clock) begin
        int g;
        logic [NREQ-1:0] er;
        exp_t e;
        if (reset) begin
            m_on = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_rem = 0; m_ptr = 0;
            m_ops = 0; m_div0 = 0;
            sb.delete();
        end else if (m_on) begin
            g  = pick(drv_valid, m_ptr);
            er = '0;
            if (!m_busy && g >= 0) er[g] = 1'b1;
            check("req_ready", bus.req_ready, er);
            check("busy", busy, m_busy);
            check("rsp_valid", bus.rsp_valid, m_busy && m_rem == 0);
            if (m_busy) begin
                if (m_rem == 0) begin
                    if (drv_rsp_ready) begin
                        m_busy = 1'b0;
                        m_ops  = (m_ops + 1) % 65536;
                        if (m_err) m_div0 = (m_div0 + 1) % 65536;
                    end
                end else begin
                    m_rem--;
                end
            end else if (g >= 0) begin
                e.id = IDW'(g);
                if (drv_y[g] == 0) begin
                    e.q = '0; e.r = '0; e.err = 1'b1; m_rem = 0;
                end else begin
                    e.q = drv_x[g] / drv_y[g]; e.r = drv_x[g] % drv_y[g]; e.err = 1'b0; m_rem = N;
                end
                sb.push_back(e);
                m_err  = e.err;
                m_busy = 1'b1;
                m_ptr  = (g + 1) % NREQ;
            end
        end
    end

    // Response monitor: content must match the oldest expected entry while
    // presented, and the entry retires on the handshake.
    always @(negedge clock) begin
        exp_t e;
        if (m_on && !reset && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb[0];
                check("rsp_id", bus.rsp_id, e.id);
                check("rsp_q", bus.rsp_q, e.q);
                check("rsp_r", bus.rsp_r, e.r);
                check("rsp_error", bus.rsp_error, e.err);
                if (drv_rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold all raised valids until each is accepted, dropping each on accept.
    task automatic wait_accept();
        int t = 0;
        logic [NREQ-1:0] acc;
        while (drv_valid != '0 && t < 200) begin
            @(negedge clock);
            acc = drv_valid & bus.req_ready;
            step();
            drv_valid = drv_valid & ~acc;
            t++;
        end
        if (drv_valid != '0) begin
            check("accept_timeout", drv_valid, 0);
            drv_valid = '0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_busy || sb.size() != 0) && t < 200) begin
            step();
            t++;
        end
        if (m_busy || sb.size() != 0) check("idle_timeout", sb.size(), 0);
        step();
    endtask

    task automatic issue(input int i, input int x, input int y);
        drv_x[i] = N'(x);
        drv_y[i] = N'(y);
        drv_valid[i] = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drv_valid = '0;
        drv_rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            drv_x[i] = '0;
            drv_y[i] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_q", bus.rsp_q, 0);
        check("reset_rsp_r", bus.rsp_r, 0);
        check("reset_rsp_id", bus.rsp_id, 0);
        check("reset_rsp_error", bus.rsp_error, 0);
        step();
        reset = 1'b0;

        // Single divide from requester 0
        issue(0, 13, 3);
        wait_accept();
        wait_idle();

        // Simultaneous requests, then a third round after the pointer wraps
        issue(0, 7, 2);
        issue(1, 9, 4);
        wait_accept();
        wait_idle();
        issue(0, 10, 3);
        issue(1, 11, 5);
        wait_accept();
        wait_idle();

        // Divide by zero, then a normal op
        issue(1, 5, 0);
        wait_accept();
        wait_idle();
        issue(0, 15, 1);
        wait_accept();
        wait_idle();

        // Response stalled with another requester waiting
        drv_rsp_ready = 1'b0;
        issue(0, 3, 7);
        wait_accept();
        issue(1, 6, 2);
        repeat (14) step();
        drv_rsp_ready = 1'b1;
        wait_accept();
        wait_idle();

        // Reset two cycles into the shift phase
        issue(0, 9, 2);
        wait_accept();
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("midreset_busy", busy, 0);
        check("midreset_rsp_valid", bus.rsp_valid, 0);
        step();
        issue(1, 14, 3);
        issue(0, 12, 5);
        wait_accept();
        wait_idle();

        // Random traffic with legal withdrawals, stalls and occasional reset
        for (int c = 0; c < 3000; c++) begin
            logic [NREQ-1:0] acc;
            @(negedge clock);
            acc = drv_valid & bus.req_ready;
            step();
            drv_valid = drv_valid & ~acc;
            for (int i = 0; i < NREQ; i++) begin
                if (!drv_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drv_x[i] = N'($urandom);
                        drv_y[i] = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
                        drv_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    drv_valid[i] = 1'b0;
                end
            end
            drv_rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        drv_valid = '0;
        reset = 1'b0;
        drv_rsp_ready = 1'b1;
        wait_idle();

`ifdef DIV_ARB_STATS_EN
        check("stat_ops", stat_ops, m_ops);
        check("stat_div0", stat_div0, m_div0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
